// File: rtl/turn_scheduler.sv
// Turn sequencer for the game: walks through surviving players, runs the per-step
// countdown, counts rounds and reports game over with the sole survivor.
module turn_scheduler #(
  parameter int MAX_PLAYER_CNT      = 7,
  parameter int LOG2_MAX_PLAYER_CNT = 3,
  parameter int MAX_STEP_TIME       = 15,
  parameter int LOG2_MAX_STEP_TIME  = 4,
  parameter int LOG2_MAX_ROUND      = 12,
  parameter int TICKS_PER_SEC       = 50_000_000
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [MAX_PLAYER_CNT-1:0]      alive,
  input  logic                           step_done,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] current_player,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] next_player,
  output logic [LOG2_MAX_STEP_TIME-1:0]  step_timer,
  output logic [LOG2_MAX_ROUND-1:0]      round,
  output logic                           turn_start,
  output logic                           playing,
  output logic                           game_over,
  output logic [LOG2_MAX_PLAYER_CNT-1:0] winner
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [LOG2_MAX_STEP_TIME-1:0] STEP_FULL = LOG2_MAX_STEP_TIME'(MAX_STEP_TIME);
  localparam logic [LOG2_MAX_ROUND-1:0] ROUND_ONE = LOG2_MAX_ROUND'(1);

  typedef enum logic [1:0] {S_IDLE, S_PLAYING, S_ADVANCE, S_OVER} state_t;

  state_t                         state_q;
  logic [LOG2_MAX_PLAYER_CNT-1:0] cur_q;
  logic [LOG2_MAX_PLAYER_CNT-1:0] winner_q;
  logic [LOG2_MAX_STEP_TIME-1:0]  timer_q;
  logic [LOG2_MAX_ROUND-1:0]      round_q;
  logic [TICK_W-1:0]              tick_q;
  logic                           turn_start_q;

  logic [LOG2_MAX_PLAYER_CNT-1:0] nxt_player;
  logic                           nxt_found;
  logic                           cur_alive;
  logic                           few_alive;

  // Cyclic scan from cur+1; with cur=0 this yields the lowest alive player,
  // and with a single survivor it yields that survivor (reused as winner).
  always_comb begin
    int p;
    nxt_player = '0;
    nxt_found  = 1'b0;
    cur_alive  = 1'b0;
    for (int k = 1; k <= MAX_PLAYER_CNT; k++) begin
      p = int'(cur_q) + k;
      if (p > MAX_PLAYER_CNT) p = p - MAX_PLAYER_CNT;
      if (!nxt_found && alive[p-1]) begin
        nxt_found  = 1'b1;
        nxt_player = LOG2_MAX_PLAYER_CNT'(p);
      end
    end
    for (int i = 0; i < MAX_PLAYER_CNT; i++) begin
      if (int'(cur_q) == i + 1) cur_alive = alive[i];
    end
  end

  assign few_alive = ((alive & (alive - 1'b1)) == '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      winner_q     <= '0;
      timer_q      <= '0;
      round_q      <= '0;
      tick_q       <= '0;
      turn_start_q <= 1'b0;
    end else begin
      turn_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            tick_q <= '0;
            if (few_alive) begin
              state_q  <= S_OVER;
              winner_q <= nxt_player;
            end else begin
              state_q      <= S_PLAYING;
              cur_q        <= nxt_player;
              timer_q      <= STEP_FULL;
              round_q      <= ROUND_ONE;
              turn_start_q <= 1'b1;
            end
          end
        end
        S_PLAYING: begin
          if (step_done) begin
            state_q <= S_ADVANCE;
          end else begin
            if (tick_q == TICK_LAST) begin
              tick_q <= '0;
              if (timer_q != '0) timer_q <= timer_q - 1'b1;
              if (timer_q <= 1) state_q <= S_ADVANCE;
            end else begin
              tick_q <= tick_q + 1'b1;
            end
            if (!cur_alive) state_q <= S_ADVANCE;
          end
        end
        S_ADVANCE: begin
          tick_q <= '0;
          if (few_alive) begin
            state_q  <= S_OVER;
            winner_q <= nxt_player;
            cur_q    <= '0;
            timer_q  <= '0;
          end else begin
            state_q      <= S_PLAYING;
            cur_q        <= nxt_player;
            timer_q      <= STEP_FULL;
            turn_start_q <= 1'b1;
            // Scan wrapped past the highest player: a new round begins.
            if (nxt_player <= cur_q && round_q != '1) round_q <= round_q + 1'b1;
          end
        end
        S_OVER: begin
          timer_q <= '0;
          if (start) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            winner_q <= '0;
            round_q  <= '0;
            tick_q   <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign current_player = cur_q;
  assign next_player    = nxt_player;
  assign step_timer     = timer_q;
  assign round          = round_q;
  assign turn_start     = turn_start_q;
  assign playing        = (state_q == S_PLAYING) || (state_q == S_ADVANCE);
  assign game_over      = (state_q == S_OVER);
  assign winner         = winner_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Directed bench for turn_scheduler with a short second (4 ticks) and 3 s steps;
// round counter narrowed to 2 bits so saturation at 3 is reachable quickly.
module tb_turn_scheduler;

  logic       clock = 1'b0;
  logic       reset_n, start, step_done;
  logic [6:0] alive;
  logic [2:0] current_player, next_player, winner;
  logic [1:0] step_timer;
  logic [1:0] round;
  logic       turn_start, playing, game_over;

  int total = 0;
  int bad   = 0;

  turn_scheduler #(
    .MAX_PLAYER_CNT(7), .LOG2_MAX_PLAYER_CNT(3),
    .MAX_STEP_TIME(3), .LOG2_MAX_STEP_TIME(2),
    .LOG2_MAX_ROUND(2), .TICKS_PER_SEC(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .alive(alive),
    .step_done(step_done), .current_player(current_player),
    .next_player(next_player), .step_timer(step_timer), .round(round),
    .turn_start(turn_start), .playing(playing), .game_over(game_over),
    .winner(winner)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-18s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic do_step();
    step_done = 1'b1;
    cyc();
    step_done = 1'b0;
    cyc();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; step_done = 1'b0; alive = 7'b0000101;
    cyc(); cyc();
    check("rst_cur", current_player, 0);
    check("rst_round", round, 0);
    check("rst_timer", step_timer, 0);
    check("rst_over", game_over, 0);
    check("rst_play", playing, 0);
    check("rst_ts", turn_start, 0);
    check("idle_next", next_player, 1);
    reset_n = 1'b1;
    step_done = 1'b1; cyc(); step_done = 1'b0;
    check("idle_stepdone", playing, 0);

    // Two players (1 and 3): start, then two completed steps
    start = 1'b1; cyc(); start = 1'b0;
    check("start_cur", current_player, 1);
    check("start_round", round, 1);
    check("start_timer", step_timer, 3);
    check("start_ts", turn_start, 1);
    check("start_next", next_player, 3);
    cyc();
    check("ts_pulse", turn_start, 0);
    step_done = 1'b1; cyc(); step_done = 1'b0;
    check("adv_cur_held", current_player, 1);
    check("adv_ts", turn_start, 0);
    cyc();
    check("step1_cur", current_player, 3);
    check("step1_ts", turn_start, 1);
    check("step1_round", round, 1);
    do_step();
    check("step2_cur", current_player, 1);
    check("step2_round", round, 2);

    // Timeout with players 1 and 2: timer 3,2,1 over 4-tick seconds
    alive = 7'b0000011;
    for (int i = 1; i <= 13; i++) begin
      cyc();
      if (i == 3)  check("to_t3", step_timer, 3);
      if (i == 4)  check("to_t2", step_timer, 2);
      if (i == 8)  check("to_t1", step_timer, 1);
      if (i == 12) check("to_adv_cur", current_player, 1);
      if (i == 12) check("to_adv_timer", step_timer, 0);
    end
    check("to_cur", current_player, 2);
    check("to_timer", step_timer, 3);
    check("to_ts", turn_start, 1);
    check("to_round", round, 2);

    // step_done coincident with the tick that would take timer 2 -> 1
    for (int i = 1; i <= 7; i++) cyc();
    check("co_timer", step_timer, 2);
    step_done = 1'b1; cyc(); step_done = 1'b0;
    check("co_nodec", step_timer, 2);
    cyc();
    check("co_cur", current_player, 1);
    check("co_round", round, 3);

    // Player 1 loses last general mid-step -> game over, winner 3
    alive = 7'b0000100;
    cyc();
    check("drop_adv", playing, 1);
    cyc();
    check("over_flag", game_over, 1);
    check("over_winner", winner, 3);
    check("over_cur", current_player, 0);
    check("over_timer", step_timer, 0);
    check("over_round", round, 3);
    start = 1'b1; cyc(); start = 1'b0;
    check("back_idle_over", game_over, 0);
    check("back_idle_round", round, 0);
    check("back_idle_win", winner, 0);

    // Round saturation at 3 with players 1 and 2
    alive = 7'b0000011;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 0; i < 6; i++) do_step();
    check("sat_cur", current_player, 1);
    check("sat_round", round, 3);

    // Reset in the middle of play
    reset_n = 1'b0; cyc(); reset_n = 1'b1;
    check("midrst_cur", current_player, 0);
    check("midrst_round", round, 0);
    check("midrst_play", playing, 0);
    check("midrst_over", game_over, 0);

    // Nobody alive at start -> straight to over, no winner
    alive = 7'b0000000;
    start = 1'b1; cyc(); start = 1'b0;
    check("none_over", game_over, 1);
    check("none_winner", winner, 0);
    check("none_cur", current_player, 0);
    check("none_next", next_player, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
